// File: rtl/control_sequencer.sv
// Microcode step counter and control-strobe decoder for the 8-bit bus CPU.
// Each bus transfer takes two steps: the source drives in step n and the destination loads in step n+1.
module control_sequencer #(
  parameter logic [3:0] OP_NOP = 4'h0,
  parameter logic [3:0] OP_LDA = 4'h1,
  parameter logic [3:0] OP_ADD = 4'h2,
  parameter logic [3:0] OP_SUB = 4'h3,
  parameter logic [3:0] OP_LDI = 4'h5,
  parameter logic [3:0] OP_JMP = 4'h6,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       main_clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [3:0] step,
  output logic       halted,
  output logic       instr_done,
  output logic       pc_out_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out_en,
  output logic       ir_load,
  output logic       ir_out_en,
  output logic       a_load,
  output logic       a_out_en,
  output logic       b_load,
  output logic       alu_out_en,
  output logic       alu_sub,
  output logic       out_load
);

  typedef enum logic [2:0] {
    K_NOP,
    K_LDA,
    K_ALU,
    K_LDI,
    K_JMP,
    K_OUT,
    K_HLT
  } kind_e;

  typedef struct packed {
    logic pc_out_en;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out_en;
    logic ir_load;
    logic ir_out_en;
    logic a_load;
    logic a_out_en;
    logic b_load;
    logic alu_out_en;
    logic alu_sub;
    logic out_load;
    logic instr_done;
  } ctl_t;

  localparam logic [3:0] MAX_STEP = 4'd9;
  localparam logic [3:0] HLT_STEP = 4'd4;

  kind_e      kind;
  logic [3:0] last_step;
  logic       is_sub;
  logic       active;
  ctl_t       ctl;

  // Unlisted opcodes fall through to the NOP class.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    kind = K_NOP;
    if (opcode == OP_NOP)                          kind = K_NOP;
    else if (opcode == OP_LDA)                     kind = K_LDA;
    else if (opcode == OP_ADD || opcode == OP_SUB) kind = K_ALU;
    else if (opcode == OP_LDI)                     kind = K_LDI;
    else if (opcode == OP_JMP)                     kind = K_JMP;
    else if (opcode == OP_OUT)                     kind = K_OUT;
    else if (opcode == OP_HLT)                     kind = K_HLT;
  end

  always_comb begin
    last_step = 4'd3;
    case (kind)
      K_NOP:               last_step = 4'd3;
      K_LDA:               last_step = 4'd7;
      K_ALU:               last_step = 4'd9;
      K_LDI, K_JMP, K_OUT: last_step = 4'd5;
      K_HLT:               last_step = HLT_STEP;
      default:             last_step = 4'd3;
    endcase
  end

  assign is_sub = (opcode == OP_SUB);
  assign active = !reset && run && !halted;

  // The NOP-class end at T3 is the one decision that looks at opcode before T4.
  always_comb begin
    ctl = '0;
    if (active) begin
      case (step)
        4'd0: ctl.pc_out_en = 1'b1;
        4'd1: begin
          ctl.mar_load = 1'b1;
          ctl.pc_inc   = 1'b1;
        end
        4'd2: ctl.ram_out_en = 1'b1;
        4'd3: begin
          ctl.ir_load    = 1'b1;
          ctl.instr_done = (kind == K_NOP);
        end
        4'd4: begin
          ctl.ir_out_en = (kind == K_LDA) || (kind == K_ALU) || (kind == K_LDI) || (kind == K_JMP);
          ctl.a_out_en  = (kind == K_OUT);
        end
        4'd5: begin
          ctl.mar_load   = (kind == K_LDA) || (kind == K_ALU);
          ctl.a_load     = (kind == K_LDI);
          ctl.pc_load    = (kind == K_JMP);
          ctl.out_load   = (kind == K_OUT);
          ctl.instr_done = (kind == K_LDI) || (kind == K_JMP) || (kind == K_OUT);
        end
        4'd6: ctl.ram_out_en = (kind == K_LDA) || (kind == K_ALU);
        4'd7: begin
          ctl.a_load     = (kind == K_LDA);
          ctl.b_load     = (kind == K_ALU);
          ctl.instr_done = (kind == K_LDA);
        end
        4'd8: begin
          ctl.alu_out_en = (kind == K_ALU);
          ctl.alu_sub    = (kind == K_ALU) && is_sub;
        end
        4'd9: begin
          ctl.a_load     = (kind == K_ALU);
          ctl.alu_sub    = (kind == K_ALU) && is_sub;
          ctl.instr_done = (kind == K_ALU);
        end
        default: ctl = '0;
      endcase
    end
  end

  assign {pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ir_load, ir_out_en,
          a_load, a_out_en, b_load, alu_out_en, alu_sub, out_load, instr_done} = ctl;

  // Step/halt sequencing; an out-of-range step recovers to T0 on its own.
  always_ff @(posedge main_clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      step   <= '0;
      halted <= 1'b0;
    end else if (step > MAX_STEP) begin
      step <= '0;
    end else if (run && !halted) begin
      if (kind == K_HLT && step == HLT_STEP) begin
        halted <= 1'b1;
      end else if (step >= last_step) begin
        step <= '0;
      end else begin
        step <= step + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: a queue-of-micro-ops reference model, per-cycle comparison, directed and random phases.
module tb_control_sequencer;

  logic       main_clock = 1'b0;
  logic       reset      = 1'b1;
  logic       run        = 1'b0;
  logic [3:0] opcode     = 4'h0;
  logic [3:0] step;
  logic       halted, instr_done;
  logic       pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ir_load, ir_out_en;
  logic       a_load, a_out_en, b_load, alu_out_en, alu_sub, out_load;

  always #5 main_clock = ~main_clock;

  control_sequencer dut (
    .main_clock (main_clock),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .step       (step),
    .halted     (halted),
    .instr_done (instr_done),
    .pc_out_en  (pc_out_en),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_out_en (ram_out_en),
    .ir_load    (ir_load),
    .ir_out_en  (ir_out_en),
    .a_load     (a_load),
    .a_out_en   (a_out_en),
    .b_load     (b_load),
    .alu_out_en (alu_out_en),
    .alu_sub    (alu_sub),
    .out_load   (out_load)
  );

  // Word layout, bit 13 down to 0.
  localparam logic [13:0] W_PC_OUT  = 14'h2000;
  localparam logic [13:0] W_PC_INC  = 14'h1000;
  localparam logic [13:0] W_PC_LD   = 14'h0800;
  localparam logic [13:0] W_MAR_LD  = 14'h0400;
  localparam logic [13:0] W_RAM_OUT = 14'h0200;
  localparam logic [13:0] W_IR_LD   = 14'h0100;
  localparam logic [13:0] W_IR_OUT  = 14'h0080;
  localparam logic [13:0] W_A_LD    = 14'h0040;
  localparam logic [13:0] W_A_OUT   = 14'h0020;
  localparam logic [13:0] W_B_LD    = 14'h0010;
  localparam logic [13:0] W_ALU_OUT = 14'h0008;
  localparam logic [13:0] W_SUB     = 14'h0004;
  localparam logic [13:0] W_OUT_LD  = 14'h0002;
  localparam logic [13:0] W_DONE    = 14'h0001;

  logic [13:0] dut_word;
  assign dut_word = {pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ir_load, ir_out_en,
                     a_load, a_out_en, b_load, alu_out_en, alu_sub, out_load, instr_done};

  typedef struct {
    logic [13:0] w;
    bit          halt;
  } uop_t;

  uop_t q[$];
  int   m_step   = 0;
  bit   m_halted = 1'b0;
  bit   m_valid  = 1'b0;
  int   cur_op   = 0;
  int   force_op = -1;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [13:0] s_word;
  logic [3:0]  s_step;
  logic        s_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [13:0] w, input bit h);
    uop_t u;
    u.w    = w;
    u.halt = h;
    q.push_back(u);
  endfunction

  // One instruction expands into its list of micro-op words.
  function automatic void build(input int op);
    push(W_PC_OUT, 0);
    push(W_MAR_LD | W_PC_INC, 0);
    push(W_RAM_OUT, 0);
    case (op)
      1: begin
        push(W_IR_LD, 0); push(W_IR_OUT, 0); push(W_MAR_LD, 0);
        push(W_RAM_OUT, 0); push(W_A_LD | W_DONE, 0);
      end
      2, 3: begin
        push(W_IR_LD, 0); push(W_IR_OUT, 0); push(W_MAR_LD, 0);
        push(W_RAM_OUT, 0); push(W_B_LD, 0);
        push(W_ALU_OUT | ((op == 3) ? W_SUB : 14'h0), 0);
        push(W_A_LD | W_DONE | ((op == 3) ? W_SUB : 14'h0), 0);
      end
      5:  begin push(W_IR_LD, 0); push(W_IR_OUT, 0); push(W_A_LD | W_DONE, 0); end
      6:  begin push(W_IR_LD, 0); push(W_IR_OUT, 0); push(W_PC_LD | W_DONE, 0); end
      14: begin push(W_IR_LD, 0); push(W_A_OUT, 0); push(W_OUT_LD | W_DONE, 0); end
      15: begin push(W_IR_LD, 0); push(14'h0, 1); end
      default: push(W_IR_LD | W_DONE, 0);
    endcase
  endfunction

  // Drive one clock of inputs, compare against the model, then advance the model.
  task automatic cycle(input bit r, input bit rn);
    logic [13:0] exp_w;
    uop_t        u;
    @(negedge main_clock);
    if (q.size() == 0) cur_op = (force_op >= 0) ? force_op : int'($urandom_range(15));
    reset  = r;
    run    = rn;
    opcode = (m_step >= 3) ? 4'(cur_op) : 4'($urandom_range(15));
    if (q.size() == 0 && !m_halted) build(cur_op);
    exp_w = (r || m_halted || !rn) ? 14'h0 : q[0].w;
    #1;
    s_word   = dut_word;
    s_step   = step;
    s_halted = halted;
    check("strobes", 32'(s_word), 32'(exp_w));
    if (m_valid) begin
      check("step", 32'(s_step), 32'(m_step));
      check("halted", 32'(s_halted), 32'(m_halted));
    end
    check("one_out_en", 32'($countones({pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en}) <= 1), 32'd1);
    check("inc_and_load", 32'(pc_inc & pc_load), 32'd0);
    @(posedge main_clock);
    if (r) begin
      q.delete();
      m_step   = 0;
      m_halted = 1'b0;
      m_valid  = 1'b1;
    end else if (!m_halted && rn) begin
      u = q.pop_front();
      if (u.halt) begin
        m_halted = 1'b1;
        q.delete();
      end else if (q.size() == 0) begin
        m_step = 0;
      end else begin
        m_step++;
      end
    end
  endtask

  initial begin
    int t1_steps[5];
    int last_tab[16];
    int a_cnt;
    int done_at;
    t1_steps = '{0, 1, 2, 3, 0};
    last_tab = '{3, 7, 9, 9, 3, 5, 5, 3, 3, 3, 3, 3, 3, 3, 5, -1};

    // Fetch-only NOP loop after reset.
    force_op = 0;
    cycle(1, 1);
    check("t1_reset_strobes", 32'(s_word), 32'd0);
    cycle(1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1);
      check("t1_step", 32'(s_step), 32'(t1_steps[i]));
      check("t1_done", 32'(s_word[0]), 32'(i == 3));
      if (i == 1) check("t1_fetch_t1", 32'(s_word), 32'(W_MAR_LD | W_PC_INC));
    end

    // ADD then SUB.
    for (int op = 2; op <= 3; op++) begin
      force_op = op;
      cycle(1, 1);
      for (int i = 0; i < 10; i++) begin
        cycle(0, 1);
        if (i == 7) check("t2_b_load", 32'(s_word[4]), 32'd1);
        if (i == 8) check("t2_alu_out", 32'(s_word[3]), 32'd1);
        if (i >= 8) check("t2_alu_sub", 32'(s_word[2]), 32'(op == 3));
        if (i == 9) check("t2_a_load_done", 32'(s_word & (W_A_LD | W_DONE)), 32'(W_A_LD | W_DONE));
      end
      cycle(0, 1);
      check("t2_wrap", 32'(s_step), 32'd0);
    end

    // HLT freezes everything until reset.
    force_op = 15;
    cycle(1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1'($urandom_range(1)));
      check("t3_step_frozen", 32'(s_step), 32'd4);
      check("t3_halted", 32'(s_halted), 32'd1);
      check("t3_quiet", 32'(s_word), 32'd0);
    end
    force_op = 0;
    cycle(1, 1);
    cycle(0, 1);
    check("t3_reset_step", 32'(s_step), 32'd0);
    check("t3_reset_halted", 32'(s_halted), 32'd0);

    // Run pause at T5 of LDA.
    force_op = 1;
    cycle(1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0);
      check("t4_hold_step", 32'(s_step), 32'd5);
      check("t4_hold_mar", 32'(s_word[10]), 32'd0);
    end
    cycle(0, 1);
    check("t4_resume_step", 32'(s_step), 32'd5);
    check("t4_resume_mar", 32'(s_word[10]), 32'd1);
    cycle(0, 1);
    check("t4_next_step", 32'(s_step), 32'd6);

    // Reset at T8 of SUB.
    force_op = 3;
    cycle(1, 1);
    a_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 1);
      a_cnt += int'(s_word[6]);
    end
    check("t5_at_t8", 32'(s_step), 32'd8);
    cycle(1, 1);
    a_cnt += int'(s_word[6]);
    check("t5_reset_quiet", 32'(s_word), 32'd0);
    cycle(0, 1);
    a_cnt += int'(s_word[6]);
    check("t5_restart_step", 32'(s_step), 32'd0);
    check("t5_restart_pc_out", 32'(s_word[13]), 32'd1);
    check("t5_no_a_load", 32'(a_cnt), 32'd0);

    // Opcode sweep: where does instr_done land.
    for (int op = 0; op < 15; op++) begin
      force_op = op;
      cycle(1, 1);
      done_at = -1;
      for (int k = 0; k < 12; k++) begin
        cycle(0, 1);
        if (s_word[0] && done_at < 0) done_at = int'(s_step);
      end
      check($sformatf("t6_last_op%0d", op), 32'(done_at), 32'(last_tab[op]));
    end

    // Random traffic.
    force_op = -1;
    cycle(1, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) == 0, $urandom_range(99) < 85);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
